// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU control decoder),
// FSM state encoding and multiply iteration count.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_ORI  = 4'd8;
  localparam logic [3:0] ALU_SRAV = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiply datapath: one partial-product step per cycle while step
// is high; product presents the accumulator value after the current step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] multiplicand_in,
  input  logic [DATA_W-1:0] multiplier_in,
  output logic              last,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] multiplicand;
  logic [DATA_W-1:0] multiplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;

  // Combinational next-acc lets the final step be latched without an extra cycle.
  assign product = multiplier[0] ? acc + multiplicand : acc;
  assign last    = step && (count == CNT_W'(MUL_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      count        <= '0;
    end else if (load) begin
      multiplicand <= multiplicand_in;
      multiplier   <= multiplier_in;
      acc          <= '0;
      count        <= '0;
    end else if (step) begin
      acc          <= product;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops plus a 32-cycle shift-add multiply,
// with a start/ready/done handshake and registered result/zero flag.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [1:0]        state;
  logic [DATA_W-1:0] op_result;
  logic              accept;
  logic              mul_load;
  logic              mul_step;
  logic              mul_last;
  logic [DATA_W-1:0] mul_product;

  assign ready_o  = (state == ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign accept   = ready_o && start_i;
  assign mul_load = accept && (ctrl_i == ALU_MUL);
  assign mul_step = (state == ST_MUL);

  always_comb begin
    op_result = '0;
    case (ctrl_i)
      ALU_AND:  op_result = src1_i & src2_i;
      ALU_OR:   op_result = src1_i | src2_i;
      ALU_ADD:  op_result = src1_i + src2_i;
      ALU_LUI:  op_result = src2_i << (DATA_W / 2);
      ALU_SRA:  op_result = $signed(src2_i) >>> shamt_i;
      ALU_SUB:  op_result = src1_i - src2_i;
      ALU_SLT:  op_result = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_ORI:  op_result = src1_i | {{(DATA_W-16){1'b0}}, src2_i[15:0]};
      ALU_SRAV: op_result = $signed(src2_i) >>> src1_i[4:0];
      default:  op_result = '0;
    endcase
  end

  alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk             (clk_i),
    .rst             (rst_i),
    .load            (mul_load),
    .step            (mul_step),
    .multiplicand_in (src1_i),
    .multiplier_in   (src2_i),
    .last            (mul_last),
    .product         (mul_product)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mul_load) begin
            state <= ST_MUL;
          end else if (accept) begin
            result_o <= op_result;
            zero_o   <= (op_result == '0);
            state    <= ST_DONE;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            result_o <= mul_product;
            zero_o   <= (mul_product == '0);
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done_o pulses.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        ready_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  alu_multicycle #(.DATA_W(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result_o, e.res);
        check({e.name, "_zero"}, 32'(zero_o), 32'(e.zero));
        check({e.name, "_done_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] er, input bit push,
                       output int unsigned acc_cyc);
    int unsigned w;
    w = 0;
    @(negedge clk_i);
    while (ready_o !== 1'b1 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    if (ready_o !== 1'b1) check({nm, "_ready_timeout"}, 32'(ready_o), 32'd1);
    start_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    @(posedge clk_i);
    #1;
    acc_cyc = cyc;
    start_i = 1'b0;
    if (push)
      sb.push_back('{res: er, zero: (er == 32'd0), cyc: acc_cyc + ((c == ALU_MUL) ? 32'd32 : 32'd0), name: nm});
  endtask

  initial begin
    int unsigned na;
    int unsigned w;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", 32'(zero_o), 32'd1);

    issue("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, na);
    issue("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, na);
    issue("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b1, na);
    issue("slt_false", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, na);
    issue("sra", ALU_SRA, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b1, na);
    issue("srav", ALU_SRAV, 32'h24, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b1, na);
    issue("lui", ALU_LUI, 32'h0, 32'h1234, 5'd0, 32'h1234_0000, 1'b1, na);
    issue("ori", ALU_ORI, 32'hF0F0_0000, 32'hFFFF_00FF, 5'd0, 32'hF0F0_00FF, 1'b1, na);
    issue("and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b1, na);
    issue("or", ALU_OR, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'hFF0F_FF0F, 1'b1, na);
    issue("undef12", 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 32'h0, 1'b1, na);
    issue("undef4", 4'd4, 32'h1, 32'h2, 5'd1, 32'h0, 1'b1, na);

    // 0x12345 * 0x6789 = 74565 * 26505 = 1976345325 = 0x75CCA2ED
    issue("mul", ALU_MUL, 32'h0001_2345, 32'h0000_6789, 5'd0, 32'h75CC_A2ED, 1'b1, na);
    for (int k = 0; k < 33; k++) begin
      @(negedge clk_i);
      check("mul_ready_low", 32'(ready_o), 32'd0);
    end
    @(negedge clk_i);
    check("mul_ready_back", 32'(ready_o), 32'd1);

    issue("mul_ones", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b1, na);

    // start held high with scrambled operands while a multiply runs
    @(negedge clk_i);
    w = 0;
    while (ready_o !== 1'b1 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    start_i = 1'b1;
    ctrl_i  = ALU_MUL;
    src1_i  = 32'd3;
    src2_i  = 32'd7;
    @(posedge clk_i);
    #1;
    na = cyc;
    sb.push_back('{res: 32'd21, zero: 1'b0, cyc: na + 32, name: "held_mul"});
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) break;
      ctrl_i = 4'($urandom_range(0, 15));
      src1_i = $urandom;
      src2_i = $urandom;
    end
    ctrl_i = ALU_ADD;
    src1_i = 32'd10;
    src2_i = 32'd20;
    @(posedge clk_i);
    #1;
    check("held_accept_cycle", cyc, na + 34);
    sb.push_back('{res: 32'd30, zero: 1'b0, cyc: cyc, name: "held_add"});
    start_i = 1'b0;

    // reset partway through a multiply; no expectation is queued for it
    issue("mul_abort", ALU_MUL, 32'h0000_0003, 32'h0000_0005, 5'd0, 32'd0, 1'b0, na);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    check("abort_zero", 32'(zero_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    issue("add_after_rst", ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b1, na);

    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    @(negedge clk_i);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
